// File: rtl/pin_router_pkg.sv
// Shared types and helpers for pin_group_router: FSM state encoding,
// default parameter values and flat pad-bus index arithmetic.
package pin_router_pkg;

  typedef enum logic {
    ST_ACTIVE = 1'b0,
    ST_DRAIN  = 1'b1
  } router_state_t;

  localparam int DEF_NUM_GROUPS    = 4;
  localparam int DEF_GROUP_WIDTH   = 8;
  localparam int DEF_NUM_TARGETS   = 2;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_GUARD_CYCLES  = 16;

  // Select field width; a single-target router still carries a 1-bit field.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a counter that must reach n-1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // LSB of pad (group g, target t) in the flat pad buses.
  function automatic int pad_lsb(input int g, input int t,
                                 input int num_targets, input int group_width);
    return (g * num_targets + t) * group_width;
  endfunction

endpackage

// File: rtl/sel_debounce.sv
// Two-flop synchroniser plus stability debouncer for one group's target
// select. Out-of-range candidates are never accepted.
module sel_debounce
  import pin_router_pkg::*;
#(
  parameter int SEL_W         = 1,
  parameter int NUM_TARGETS   = DEF_NUM_TARGETS,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SEL_W-1:0] sel_raw,
  output logic [SEL_W-1:0] sel_db
);

  localparam int              CNT_W    = cnt_width(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SEL_W-1:0] sync1;
  logic [SEL_W-1:0] sync2;
  logic [SEL_W-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             accept;

  // The counter saturates at CNT_LAST, so a held candidate keeps being
  // re-accepted harmlessly while it stays stable.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latches.
    cnt_nxt = cnt;
    accept  = 1'b0;
    if (sync2 != cand) begin
      cnt_nxt = '0;
    end else if (cnt != CNT_LAST) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
    if ((cnt_nxt == CNT_LAST) && (int'(sync2) < NUM_TARGETS)) begin
      accept = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      cand   <= '0;
      cnt    <= '0;
      sel_db <= '0;
    end else begin
      sync1 <= sel_raw;
      sync2 <= sync1;
      cand  <= sync2;
      cnt   <= cnt_nxt;
      if (accept) begin
        sel_db <= sync2;
      end
    end
  end

endmodule

// File: rtl/pin_group_router.sv
// Routes each pin group to one of several pad sets, with a tristate guard
// interval on every target change so old and new pads never overlap.
module pin_group_router
  import pin_router_pkg::*;
#(
  parameter int NUM_GROUPS    = DEF_NUM_GROUPS,
  parameter int GROUP_WIDTH   = DEF_GROUP_WIDTH,
  parameter int NUM_TARGETS   = DEF_NUM_TARGETS,
  parameter int SEL_W         = sel_width(NUM_TARGETS),
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int GUARD_CYCLES  = DEF_GUARD_CYCLES
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [NUM_GROUPS*SEL_W-1:0]               sel_raw,
  input  logic [NUM_GROUPS*GROUP_WIDTH-1:0]         pin_out,
  input  logic [NUM_GROUPS*GROUP_WIDTH-1:0]         pin_dir,
  input  logic [NUM_GROUPS*NUM_TARGETS*GROUP_WIDTH-1:0] pad_in,
  output logic [NUM_GROUPS*NUM_TARGETS*GROUP_WIDTH-1:0] pad_out,
  output logic [NUM_GROUPS*NUM_TARGETS*GROUP_WIDTH-1:0] pad_oe,
  output logic [NUM_GROUPS*GROUP_WIDTH-1:0]         pin_in_ext,
  output logic [NUM_GROUPS*SEL_W-1:0]               sel_active,
  output logic [NUM_GROUPS-1:0]                     switching
);

  localparam int               GRP_PADS = NUM_TARGETS * GROUP_WIDTH;
  localparam int               CNT_W    = cnt_width(GUARD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GUARD_CYCLES - 1);

  if (GUARD_CYCLES < 1) begin : g_guard_check
    $error("pin_group_router: GUARD_CYCLES must be at least 1");
  end

  for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_grp
    router_state_t          state_q;
    router_state_t          state_nxt;
    logic [SEL_W-1:0]       sel_db;
    logic [SEL_W-1:0]       act_q;
    logic [SEL_W-1:0]       act_nxt;
    logic [SEL_W-1:0]       pend_q;
    logic [SEL_W-1:0]       pend_nxt;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [GROUP_WIDTH-1:0] dir_g;
    logic [GROUP_WIDTH-1:0] out_g;
    logic [GROUP_WIDTH-1:0] in_ext_q;
    logic [GRP_PADS-1:0]    pad_in_g;
    logic [GRP_PADS-1:0]    oe_q;
    logic [GRP_PADS-1:0]    po_q;
    logic                   sw_q;

    assign dir_g    = pin_dir[g*GROUP_WIDTH +: GROUP_WIDTH];
    assign out_g    = pin_out[g*GROUP_WIDTH +: GROUP_WIDTH];
    assign pad_in_g = pad_in[pad_lsb(g, 0, NUM_TARGETS, GROUP_WIDTH) +: GRP_PADS];

    sel_debounce #(
      .SEL_W         (SEL_W),
      .NUM_TARGETS   (NUM_TARGETS),
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_sel_debounce (
      .clock   (clock),
      .reset   (reset),
      .sel_raw (sel_raw[g*SEL_W +: SEL_W]),
      .sel_db  (sel_db)
    );

    // A new debounced select during DRAIN restarts the guard, even when it
    // points back at the currently committed target.
    always_comb begin
      state_nxt = state_q;
      act_nxt   = act_q;
      pend_nxt  = pend_q;
      cnt_nxt   = cnt_q;
      unique case (state_q)
        ST_ACTIVE: begin
          if (sel_db != act_q) begin
            state_nxt = ST_DRAIN;
            pend_nxt  = sel_db;
            cnt_nxt   = '0;
          end
        end
        ST_DRAIN: begin
          if (sel_db != pend_q) begin
            pend_nxt = sel_db;
            cnt_nxt  = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_nxt = ST_ACTIVE;
            act_nxt   = pend_q;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
        default: state_nxt = ST_ACTIVE;
      endcase
    end

    // Pad enables follow the next state so the old target drops on the same
    // edge that opens the guard, and the new one rises on the commit edge.
    always_ff @(posedge clock) begin
      if (reset) begin
        state_q  <= ST_ACTIVE;
        act_q    <= '0;
        pend_q   <= '0;
        cnt_q    <= '0;
        sw_q     <= 1'b0;
        in_ext_q <= '0;
        oe_q     <= '0;
        po_q     <= '0;
      end else begin
        state_q <= state_nxt;
        act_q   <= act_nxt;
        pend_q  <= pend_nxt;
        cnt_q   <= cnt_nxt;
        sw_q    <= (state_nxt == ST_DRAIN);
        if (state_q == ST_ACTIVE) begin
          in_ext_q <= pad_in_g[int'(act_q)*GROUP_WIDTH +: GROUP_WIDTH];
        end
        for (int t = 0; t < NUM_TARGETS; t++) begin
          if ((state_nxt == ST_ACTIVE) && (act_nxt == SEL_W'(t))) begin
            oe_q[t*GROUP_WIDTH +: GROUP_WIDTH] <= dir_g;
            po_q[t*GROUP_WIDTH +: GROUP_WIDTH] <= out_g;
          end else begin
            oe_q[t*GROUP_WIDTH +: GROUP_WIDTH] <= '0;
            po_q[t*GROUP_WIDTH +: GROUP_WIDTH] <= '0;
          end
        end
      end
    end

    assign pad_oe[pad_lsb(g, 0, NUM_TARGETS, GROUP_WIDTH) +: GRP_PADS]  = oe_q;
    assign pad_out[pad_lsb(g, 0, NUM_TARGETS, GROUP_WIDTH) +: GRP_PADS] = po_q;
    assign pin_in_ext[g*GROUP_WIDTH +: GROUP_WIDTH] = in_ext_q;
    assign sel_active[g*SEL_W +: SEL_W]             = act_q;
    assign switching[g]                             = sw_q;
  end

endmodule

// File: doc/pin_group_router.md
# pin_group_router

Parametrised successor to the board-level switch-driven pin multiplexing. It routes `NUM_GROUPS` slices of the Propeller pin bus, each `GROUP_WIDTH` pins wide, to one of `NUM_TARGETS` pad sets per group. Each group's target is chosen by its own synchronised, debounced select. A target change passes through a guard interval in which the whole group is tristated, so old and new pads never drive at the same time. The block sits between the `dig` core pin buses and the board top level, which instantiates the IOBUFs from `pad_out`/`pad_oe`.

## Interface
Parameters:
- `NUM_GROUPS`, 4: number of independently routed pin groups.
- `GROUP_WIDTH`, 8: pins per group.
- `NUM_TARGETS`, 2: candidate pad sets per group.
- `SEL_W`, derived as max(1, $clog2(NUM_TARGETS)): select width per group.
- `STABLE_CYCLES`, 1024: cycles a synchronised select must hold before it is accepted.
- `GUARD_CYCLES`, 16: tristate interval on a target change; must be ≥1.

Ports:
- `clock` in 1: single clock, no other clock domains in the block.
- `reset` in 1: synchronous, active-high.
- `sel_raw` in NUM_GROUPS*SEL_W: raw switch select, one field per group, asynchronous.
- `pin_out` in NUM_GROUPS*GROUP_WIDTH: core output values.
- `pin_dir` in NUM_GROUPS*GROUP_WIDTH: core directions, 1 = output.
- `pad_in` in NUM_GROUPS*NUM_TARGETS*GROUP_WIDTH: pad input values.
- `pad_out` out NUM_GROUPS*NUM_TARGETS*GROUP_WIDTH: pad drive values.
- `pad_oe` out NUM_GROUPS*NUM_TARGETS*GROUP_WIDTH: pad output enables.
- `pin_in_ext` out NUM_GROUPS*GROUP_WIDTH: external input toward the core loopback mux.
- `sel_active` out NUM_GROUPS*SEL_W: committed target per group.
- `switching` out NUM_GROUPS: group is in its guard interval.

Pad bit index is (g*NUM_TARGETS + t)*GROUP_WIDTH + b.

## Operation
- **Select path.** Each `sel_raw` field passes through a 2-flop synchroniser, then a debouncer.
  - When the synchronised value differs from the candidate, the candidate is loaded and the counter clears.
  - When the counter reaches STABLE_CYCLES-1, `sel_db` takes the candidate.
  - A candidate ≥ NUM_TARGETS is never accepted.
- **Per-group FSM, state ACTIVE.**
  - Target t = `sel_active` is driven: `pad_oe` = `pin_dir`, `pad_out` = `pin_out`. All other targets have `pad_oe` = 0 and `pad_out` = 0.
  - `pin_in_ext` takes `pad_in` of target t.
  - When `sel_db` ≠ `sel_active`: go to DRAIN, with pending ← `sel_db` and cnt ← 0.
- **Per-group FSM, state DRAIN.**
  - Every `pad_oe` of the group is 0.
  - `pin_in_ext` holds its last ACTIVE value.
  - cnt increments each cycle.
  - If `sel_db` ≠ pending: pending ← `sel_db`, cnt ← 0 (the guard restarts). This also applies when `sel_db` returns to the old target.
  - When cnt = GUARD_CYCLES-1: go to ACTIVE with `sel_active` ← pending.
- **Group independence.** Groups are fully independent; simultaneous changes in several groups run in parallel.

## Timing
- **Reset.** All outputs are registered. While `reset` is high: `pad_oe` = 0, `pad_out` = 0, `pin_in_ext` = 0, `sel_active` = 0, `switching` = 0. All groups are in ACTIVE, synchronisers/candidates/counters are 0, and `sel_db` = 0. Reset mid-DRAIN abandons the change.
- **Data latency.** One cycle from `pin_out`/`pin_dir` to `pad_out`/`pad_oe`, and from `pad_in` to `pin_in_ext`.
- **Select acceptance.** A clean `sel_raw` step that stays stable updates `sel_db` 2 + STABLE_CYCLES cycles after the step.
- **Guard window.** On the edge after `sel_db` ≠ `sel_active`, `switching` rises and the old target's `pad_oe` drops. `switching` stays high for exactly GUARD_CYCLES cycles.
- **Commit.** On the edge where `switching` falls, `sel_active` updates and the new target's `pad_oe` follows `pin_dir`.
- **No contention.** Two targets of one group are never enabled in the same cycle.

## Structure
- **Package `pin_router_pkg`:**
  - state enum `router_state_t` {ST_ACTIVE, ST_DRAIN};
  - function `sel_width(n)`;
  - localparams for the flat-index helpers.
- **Sub-module `sel_debounce`:** synchroniser, candidate and counter, parametrised by SEL_W, NUM_TARGETS and STABLE_CYCLES. One instance per group, created by generate.
- **Top block:** the FSM and routing muxes, also in a generate loop over groups.

## Test plan
- **Reset.** Hold `reset` 3 cycles with `pin_dir` all 1 → all `pad_oe` = 0, `sel_active` = 0. Release → target-0 `pad_oe` = `pin_dir` one cycle later.
- **Clean switch.** STABLE_CYCLES=8, GUARD_CYCLES=4; group 1 `sel_raw` 0→1 and hold → `switching[1]` high for exactly 4 cycles starting 11 cycles after the step. Target-0 oe = 0 throughout. `sel_active[1]` = 1 afterwards, and target 1 drives `pin_out` 0xA5. Other groups are unaffected.
- **Bounce.** Toggle `sel_raw` every 3 cycles for 40 cycles with STABLE_CYCLES=8 → `sel_db` and `switching` never change.
- **Retarget in DRAIN.** NUM_TARGETS=4; commit to 2, then to 3 during cycle 2 of the guard → guard restarts and `sel_active` = 3 after GUARD_CYCLES further cycles. No cycle shows oe on two targets; an assertion covers all cycles.
- **Invalid select.** NUM_TARGETS=3, `sel_raw` = 3 → no DRAIN entered, `sel_active` unchanged.
- **Input hold.** Drive `pad_in` 0x3C on the old target, then switch → `pin_in_ext` holds 0x3C through the guard. It then follows the new target's `pad_in` 0xC3 one cycle after commit.
